// File: rtl/exec_pkg.sv
// Execute-stage encodings and the payload carried from issue to writeback.
package exec_pkg;

   localparam int XLEN = 32;
   localparam int SHAMT_W = 5;
   localparam int RD_W = 5;

   localparam logic [2:0] FUNCT3_SLL = 3'b001;
   localparam logic [2:0] FUNCT3_SRx = 3'b101;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [RD_W-1:0] rd;
      logic            illegal;
   } shift_op_t;

endpackage : exec_pkg

// File: rtl/shifter_pkg.sv
// Shift-type encoding shared by the shifter and its users.
package shifter_pkg;

   typedef enum logic [1:0] {
      SHIFT_LEFT  = 2'd0,
      SHIFT_RIGHT = 2'd1,
      SHIFT_ARITH = 2'd2
   } shift_type_t;

endpackage : shifter_pkg

// File: rtl/shifter.sv
// Combinational barrel shifter: logical left, logical right, arithmetic right.
module shifter
   import shifter_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0]         data,
   input  logic [$clog2(N)-1:0] amount,
   input  shift_type_t          shift_type,
   output logic [N-1:0]         result
);

   // Select the shift flavour; unknown encodings produce zero.
   always_comb begin
      result = '0;
      case (shift_type)
         SHIFT_LEFT:  result = data << amount;
         SHIFT_RIGHT: result = data >> amount;
         SHIFT_ARITH: result = $unsigned($signed(data) >>> amount);
         default:     result = '0;
      endcase
   end

endmodule : shifter

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: a main (output) register plus one overflow register.
// in_ready depends only on skid occupancy, so there is no combinational path
// from out_ready back to the upstream stage.
module skid_buffer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid;
   logic [W-1:0] main_data;
   logic         skid_valid;
   logic [W-1:0] skid_data;
   logic         fire_in;
   logic         fire_out;
   logic         main_free;

   assign in_ready  = !skid_valid;
   assign fire_in   = in_valid && in_ready;
   assign fire_out  = main_valid && out_ready;
   assign main_free = !main_valid || fire_out;

   assign out_valid = main_valid;
   assign out_data  = main_data;

   // Occupancy flags; flush discards everything, including an op arriving on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_free) begin
         main_valid <= skid_valid || fire_in;
         skid_valid <= 1'b0;
      end else if (fire_in) begin
         skid_valid <= 1'b1;
      end
   end

   // Main data loads from skid first (oldest op) and otherwise from the input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_data <= '0;
      end else if (!flush && main_free) begin
         if (skid_valid) begin
            main_data <= skid_data;
         end else if (fire_in) begin
            main_data <= in_data;
         end
      end
   end

   // Skid captures an op only when main is stalled by downstream backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_data <= '0;
      end else if (!flush && !main_free && fire_in) begin
         skid_data <= in_data;
      end
   end

endmodule : skid_buffer

// File: rtl/shift_exec_stage.sv
// Execute stage for RV32I shifts: decodes funct3/funct7, shifts on the input
// side, and registers the result through a skid buffer toward writeback.
module shift_exec_stage
   import shifter_pkg::*;
   import exec_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   in_funct3,
   input  logic [6:0]   in_funct7,
   input  logic [N-1:0] in_rs1,
   input  logic [N-1:0] in_operand_b,
   input  logic [4:0]   in_rd,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic [4:0]   out_rd,
   output logic         out_illegal
);

   shift_type_t          dec_type;
   logic                 dec_illegal;
   logic [N-1:0]         shift_result;
   logic [SHAMT_W-1:0]   shamt;
   shift_op_t            new_op;
   shift_op_t            head_op;
   logic                 unused_operand_b_hi;

   // Only the low five bits select the shift distance; the rest are don't-care.
   assign shamt               = in_operand_b[SHAMT_W-1:0];
   assign unused_operand_b_hi = ^in_operand_b[N-1:SHAMT_W];

   // Map funct3/funct7 onto a shifter type; anything else is flagged illegal.
   always_comb begin
      dec_type    = SHIFT_LEFT;
      dec_illegal = 1'b1;
      if (in_funct3 == FUNCT3_SLL && in_funct7 == FUNCT7_BASE) begin
         dec_type    = SHIFT_LEFT;
         dec_illegal = 1'b0;
      end else if (in_funct3 == FUNCT3_SRx && in_funct7 == FUNCT7_BASE) begin
         dec_type    = SHIFT_RIGHT;
         dec_illegal = 1'b0;
      end else if (in_funct3 == FUNCT3_SRx && in_funct7 == FUNCT7_ALT) begin
         dec_type    = SHIFT_ARITH;
         dec_illegal = 1'b0;
      end
   end

   shifter #(
      .N (N)
   ) u_shifter (
      .data       (in_rs1),
      .amount     (shamt),
      .shift_type (dec_type),
      .result     (shift_result)
   );

   // Illegal ops still flow in order, but carry a zero result.
   always_comb begin
      new_op         = '0;
      new_op.result  = dec_illegal ? '0 : shift_result;
      new_op.rd      = in_rd;
      new_op.illegal = dec_illegal;
   end

   skid_buffer #(
      .W ($bits(shift_op_t))
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (new_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head_op)
   );

   assign out_result  = head_op.result;
   assign out_rd      = head_op.rd;
   assign out_illegal = head_op.illegal;

endmodule : shift_exec_stage

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage: decode, latency, backpressure, flush, reset.
module tb_shift_exec_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_rs1;
   logic [31:0] in_operand_b;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int n_tests = 0;
   int n_fail  = 0;

   shift_exec_stage #(
      .N (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_funct3    (in_funct3),
      .in_funct7    (in_funct7),
      .in_rs1       (in_rs1),
      .in_operand_b (in_operand_b),
      .in_rd        (in_rd),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_rd       (out_rd),
      .out_illegal  (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] rs1, input logic [31:0] b,
                         input logic [4:0] rd);
      in_valid     = 1'b1;
      in_funct3    = f3;
      in_funct7    = f7;
      in_rs1       = rs1;
      in_operand_b = b;
      in_rd        = rd;
   endtask

   initial begin
      rst          = 1'b1;
      flush        = 1'b0;
      in_valid     = 1'b0;
      in_funct3    = 3'b000;
      in_funct7    = 7'b0;
      in_rs1       = 32'h0;
      in_operand_b = 32'h0;
      in_rd        = 5'd0;
      out_ready    = 1'b1;

      #12;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_result", out_result, 32'h0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      rst = 1'b0;
      tick();

      // SLL by 31
      set_op(3'b001, 7'h00, 32'h0000_0001, 32'h0000_001F, 5'd5);
      tick();
      check("sll_valid", {31'b0, out_valid}, 32'd1);
      check("sll_result", out_result, 32'h8000_0000);
      check("sll_rd", {27'b0, out_rd}, 32'd5);
      check("sll_illegal", {31'b0, out_illegal}, 32'd0);

      // SRA with upper shamt bits set (0x24 -> 4)
      set_op(3'b101, 7'h20, 32'h8000_0000, 32'h0000_0024, 5'd7);
      tick();
      check("sra_result", out_result, 32'hF800_0000);
      check("sra_rd", {27'b0, out_rd}, 32'd7);

      set_op(3'b101, 7'h00, 32'h8000_0000, 32'h0000_0024, 5'd8);
      tick();
      check("srl_result", out_result, 32'h0800_0000);

      // shamt 0 from a negative immediate
      set_op(3'b101, 7'h20, 32'h8000_0001, 32'hFFFF_FFE0, 5'd9);
      tick();
      check("sra_zero_shamt", out_result, 32'h8000_0001);

      in_valid = 1'b0;
      tick();
      check("drain_valid", {31'b0, out_valid}, 32'd0);

      // Backpressure: A to main, B to skid, C held
      out_ready = 1'b0;
      set_op(3'b101, 7'h00, 32'h0000_00F0, 32'd1, 5'd1);
      tick();
      check("bp_a_valid", {31'b0, out_valid}, 32'd1);
      check("bp_a_result", out_result, 32'h78);
      check("bp_a_in_ready", {31'b0, in_ready}, 32'd1);
      set_op(3'b101, 7'h00, 32'h0000_00F0, 32'd2, 5'd2);
      tick();
      check("bp_b_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_b_hold", out_result, 32'h78);
      set_op(3'b101, 7'h00, 32'h0000_00F0, 32'd3, 5'd3);
      tick();
      check("bp_c_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_c_hold", out_result, 32'h78);
      check("bp_c_hold_rd", {27'b0, out_rd}, 32'd1);
      out_ready = 1'b1;
      tick();
      check("bp_b_result", out_result, 32'h3C);
      check("bp_b_rd", {27'b0, out_rd}, 32'd2);
      check("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      check("bp_c_result", out_result, 32'h1E);
      check("bp_c_rd", {27'b0, out_rd}, 32'd3);
      tick();
      check("bp_empty", {31'b0, out_valid}, 32'd0);

      // Illegal op then a legal SLL, in order
      set_op(3'b000, 7'h00, 32'h0000_1234, 32'd4, 5'd11);
      tick();
      check("ill_flag", {31'b0, out_illegal}, 32'd1);
      check("ill_result", out_result, 32'h0);
      check("ill_rd", {27'b0, out_rd}, 32'd11);
      set_op(3'b001, 7'h00, 32'h0000_1234, 32'd4, 5'd12);
      tick();
      check("after_ill_flag", {31'b0, out_illegal}, 32'd0);
      check("after_ill_result", out_result, 32'h0001_2340);
      // SLL with funct7=ALT is not a legal encoding
      set_op(3'b001, 7'h20, 32'h0000_1234, 32'd4, 5'd13);
      tick();
      check("sll_alt_illegal", {31'b0, out_illegal}, 32'd1);
      in_valid = 1'b0;
      tick();

      // Flush with both entries full, then flush vs. a firing input
      out_ready = 1'b0;
      set_op(3'b001, 7'h00, 32'h1, 32'd0, 5'd1);
      tick();
      set_op(3'b001, 7'h00, 32'h2, 32'd0, 5'd2);
      tick();
      check("fl_full_in_ready", {31'b0, in_ready}, 32'd0);
      flush = 1'b1;
      set_op(3'b001, 7'h00, 32'h3, 32'd0, 5'd3);
      tick();
      check("fl_out_valid", {31'b0, out_valid}, 32'd0);
      check("fl_in_ready", {31'b0, in_ready}, 32'd1);
      set_op(3'b001, 7'h00, 32'h4, 32'd0, 5'd4);
      tick();
      check("fl_drop_fire_in", {31'b0, out_valid}, 32'd0);
      flush    = 1'b0;
      in_valid = 1'b0;
      tick();
      check("fl_nothing_left", {31'b0, out_valid}, 32'd0);

      // Async reset mid-clock with both entries full
      set_op(3'b001, 7'h00, 32'h5, 32'd1, 5'd5);
      tick();
      set_op(3'b001, 7'h00, 32'h6, 32'd1, 5'd6);
      tick();
      in_valid = 1'b0;
      check("pre_rst_full", {31'b0, in_ready}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", {31'b0, out_valid}, 32'd0);
      check("arst_out_result", out_result, 32'h0);
      check("arst_out_rd", {27'b0, out_rd}, 32'd0);
      check("arst_in_ready", {31'b0, in_ready}, 32'd1);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      check("post_rst_empty", {31'b0, out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_shift_exec_stage
